fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage and IF/ID pipeline register. It consumes the PC-source and flush decisions produced by the branch control unit in EX. It holds the PC, requests instructions from instruction memory over a req/ack handshake, and redirects on taken branches and jumps. It presents fetched instructions to decode, with a one-entry skid buffer so a decode stall never forces a re-fetch.

## Interface
Parameters:
- `PC_WIDTH`, 32, width of PC and addresses
- `INSTR_WIDTH`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset

Ports:
- `clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_pcSrc`  in  2  00 = PC+4, 01 = `i_branch_target`, 10 = `i_jalr_target`, 11 = treated as 00
- `i_flush`  in  1  kill the instruction in IF/ID
- `i_branch_target`  in  PC_WIDTH  PC+imm target (branch, JAL)
- `i_jalr_target`  in  PC_WIDTH  rs1+imm target (JALR)
- `i_stall`  in  1  hazard unit: hold IF/ID and PC
- `o_imem_req`  out  1  fetch request
- `o_imem_addr`  out  PC_WIDTH  fetch address (= PC register)
- `i_imem_ack`  in  1  data valid for the current request; may arrive in the same cycle as the request
- `i_imem_data`  in  INSTR_WIDTH  instruction
- `o_ifid_instr`  out  INSTR_WIDTH  instruction to decode
- `o_ifid_pc`  out  PC_WIDTH  PC of `o_ifid_instr`
- `o_ifid_pc4`  out  PC_WIDTH  `o_ifid_pc` + 4
- `o_ifid_valid`  out  1  IF/ID holds a real instruction
- `o_misaligned`  out  1  sticky misaligned-target flag (only with `FETCH_MISALIGN_TRAP_EN`)

## Operation
- Signal definitions:
  - redirect = (`i_pcSrc` == 01 or 10)
  - kill = `i_flush` or redirect
  - The JALR target always has bit 0 cleared.
- States: BOOT, RUN, HOLD, HALT (HALT exists only with the macro).
- BOOT:
  - Entered on reset; lasts one cycle.
  - `o_imem_req` = 0.
  - Goes to RUN.
- RUN:
  - `o_imem_req` = 1 and `o_imem_addr` = PC.
  - Priority is kill > stall > ack.
  - kill:
    - PC loads the target selected by `i_pcSrc` (PC is unchanged if `i_pcSrc` is 00).
    - IF/ID loads a bubble; `i_imem_ack` is ignored.
    - State stays RUN.
  - `i_stall` with ack:
    - IF/ID holds.
    - The skid buffer captures {`i_imem_data`, PC}.
    - PC increments by 4.
    - Goes to HOLD.
  - `i_stall` without ack: IF/ID and PC hold.
  - ack without stall:
    - IF/ID loads {`i_imem_data`, PC, PC+4, valid = 1}.
    - PC increments by 4.
  - No ack, no stall: IF/ID loads a bubble; PC holds.
- HOLD:
  - `o_imem_req` = 0.
  - kill: drop the buffer, redirect as in RUN, load IF/ID with a bubble, go to RUN.
  - `i_stall`: hold everything.
  - Stall released: IF/ID loads the buffer with valid = 1, go to RUN.
- Bubble: instr = 32'h0000_0013 (NOP), pc = 0, pc4 = 0, valid = 0.
- PC arithmetic: modulo 2^PC_WIDTH; PC+4 wraps from 32'hFFFF_FFFC to 0 with no flag.

## Timing
- Reset values:
  - PC = `RESET_PC`, state = BOOT.
  - `o_imem_req` = 0, `o_imem_addr` = `RESET_PC`.
  - IF/ID = bubble, skid buffer empty, `o_misaligned` = 0.
- Reset asserted mid-operation returns every register to its reset value immediately, regardless of any pending ack.
- `o_imem_req` is decoded from state and `o_imem_addr` is the PC register output, so both are glitch-free.
- All IF/ID outputs are registered.
- Latency: an ack in cycle N places the instruction on the IF/ID outputs at N+1.
- Throughput: one instruction per cycle with a zero-wait memory.
- Redirect penalty:
  - The kill cycle's fetch is discarded.
  - The first target instruction is requested in cycle N+1 and reaches IF/ID at N+2 at the earliest.
- Simultaneous kill + stall + ack: the kill wins, so the instruction is dropped and PC takes the target.
- `i_flush` with `i_pcSrc` = 00: a bubble is inserted and fetching continues at the current PC.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect whose target (after clearing the JALR LSB) has bits [1:0] ≠ 00 sets `o_misaligned` = 1 and enters HALT.
  - In HALT, `o_imem_req` = 0 and IF/ID = bubble until reset.
- Not defined:
  - Redirect targets have bits [1:0] forced to 00.
  - `o_misaligned` is tied to 0 and there is no HALT state.

## Test plan
- **Reset and sequential fetch.** Release reset with `RESET_PC` = 0 and ack tied high.
  - Cycle 0: req = 0.
  - Then addr = 0, 4, 8.
  - IF/ID shows pc 0/instr A one cycle after each ack.
- **Taken branch.** In RUN at PC = 0x10, `i_pcSrc` = 01, `i_flush` = 1, `i_branch_target` = 0x40, ack = 1.
  - Next cycle: addr = 0x40, IF/ID = NOP with valid 0.
  - The following cycle: IF/ID pc = 0x40.
- **JALR.** `i_pcSrc` = 10, `i_jalr_target` = 0x101.
  - Next cycle addr = 0x100 without the macro.
  - With the macro: `o_misaligned` = 0 and fetch continues at 0x100, because 0x100 is aligned after the LSB is cleared.
- **Stall with skid buffer.** At PC = 0x20, raise `i_stall` for 3 cycles with ack = 1 on the first.
  - req drops for the remaining stall cycles.
  - IF/ID holds its old value.
  - The cycle after release: IF/ID = {instr@0x20, valid 1} and addr = 0x24.
- **Flush during HOLD.** Stall captures 0x30; then `i_flush` = 1, `i_pcSrc` = 01, target 0x80, while `i_stall` = 1.
  - The buffer is dropped.
  - IF/ID = NOP.
  - Next addr = 0x80.
- **Misaligned trap, with macro.** `i_pcSrc` = 01, target 0x42.
  - `o_misaligned` = 1 and req = 0 for all following cycles.
  - Async reset clears both.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the fetch stage's control, imem and IF/ID signals into one bundle.
// Latency: none, this is wiring only.
// Backpressure: carries i_stall and the imem req/ack handshake; slave = fetch unit, master = its environment.
interface fetch_unit_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic [1:0]             i_pcSrc;
    logic                   i_flush;
    logic [PC_WIDTH-1:0]    i_branch_target;
    logic [PC_WIDTH-1:0]    i_jalr_target;
    logic                   i_stall;
    logic                   o_imem_req;
    logic [PC_WIDTH-1:0]    o_imem_addr;
    logic                   i_imem_ack;
    logic [INSTR_WIDTH-1:0] i_imem_data;
    logic [INSTR_WIDTH-1:0] o_ifid_instr;
    logic [PC_WIDTH-1:0]    o_ifid_pc;
    logic [PC_WIDTH-1:0]    o_ifid_pc4;
    logic                   o_ifid_valid;
    logic                   o_misaligned;

    modport slave (
        input  i_pcSrc, i_flush, i_branch_target, i_jalr_target, i_stall,
        input  i_imem_ack, i_imem_data,
        output o_imem_req, o_imem_addr,
        output o_ifid_instr, o_ifid_pc, o_ifid_pc4, o_ifid_valid, o_misaligned
    );

    modport master (
        output i_pcSrc, i_flush, i_branch_target, i_jalr_target, i_stall,
        output i_imem_ack, i_imem_data,
        input  o_imem_req, o_imem_addr,
        input  o_ifid_instr, o_ifid_pc, o_ifid_pc4, o_ifid_valid, o_misaligned
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, imem req/ack fetch, IF/ID register with a one-entry skid buffer.
// Latency: ack in cycle N shows on IF/ID at N+1; a redirect target reaches IF/ID at N+2 earliest.
// Backpressure: i_stall holds PC and IF/ID; an ack taken during stall parks in the skid buffer and req drops.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: misaligned redirect sets o_misaligned and halts fetch.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic        clk,
    input  logic        i_rst_n,
    fetch_unit_if.slave bus
);
    localparam logic [INSTR_WIDTH-1:0] NOP     = INSTR_WIDTH'(32'h0000_0013);
    localparam logic [PC_WIDTH-1:0]    PC_STEP = PC_WIDTH'(4);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
        HALT = 2'd3,
`endif
        HOLD = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [PC_WIDTH-1:0]    r_pc, w_pc_nxt;
    logic [INSTR_WIDTH-1:0] r_ifid_instr, w_ifid_instr_nxt;
    logic [PC_WIDTH-1:0]    r_ifid_pc, w_ifid_pc_nxt;
    logic [PC_WIDTH-1:0]    r_ifid_pc4, w_ifid_pc4_nxt;
    logic                   r_ifid_valid, w_ifid_valid_nxt;
    logic [INSTR_WIDTH-1:0] r_skid_instr, w_skid_instr_nxt;
    logic [PC_WIDTH-1:0]    r_skid_pc, w_skid_pc_nxt;

    logic                   w_redirect;
    logic                   w_kill;
    logic [PC_WIDTH-1:0]    w_raw_target;
    logic [PC_WIDTH-1:0]    w_target;
    logic [PC_WIDTH-1:0]    w_pc4;
    logic [PC_WIDTH-1:0]    w_skid_pc4;

    assign w_redirect   = (bus.i_pcSrc == 2'b01) || (bus.i_pcSrc == 2'b10);
    assign w_kill       = bus.i_flush || w_redirect;
    // JALR targets never carry bit 0.
    assign w_raw_target = (bus.i_pcSrc == 2'b10) ? (bus.i_jalr_target & ~PC_WIDTH'(1))
                                                 : bus.i_branch_target;
    assign w_pc4        = r_pc + PC_STEP;
    assign w_skid_pc4   = r_skid_pc + PC_STEP;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misaligned, w_misaligned_nxt;
    logic w_trap;
    assign w_target = w_raw_target;
    assign w_trap   = w_redirect && (w_raw_target[1:0] != 2'b00);
`else
    // Without the trap, a redirect silently lands on the word boundary.
    assign w_target = w_raw_target & ~PC_WIDTH'(3);
`endif

    // Next-state and register-load decisions; kill beats stall, stall beats ack.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_pc4_nxt   = r_ifid_pc4;
        w_ifid_valid_nxt = r_ifid_valid;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_misaligned_nxt = r_misaligned;
`endif
        if (((r_state == RUN) || (r_state == HOLD)) && w_kill) begin
            // Kill: bubble into IF/ID, drop any parked fetch, ignore this cycle's ack.
            w_state_nxt      = RUN;
            w_ifid_instr_nxt = NOP;
            w_ifid_pc_nxt    = '0;
            w_ifid_pc4_nxt   = '0;
            w_ifid_valid_nxt = 1'b0;
            w_skid_instr_nxt = '0;
            w_skid_pc_nxt    = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_trap) begin
                w_state_nxt      = HALT;
                w_misaligned_nxt = 1'b1;
            end else if (w_redirect) begin
                w_pc_nxt = w_target;
            end
`else
            if (w_redirect) begin
                w_pc_nxt = w_target;
            end
`endif
        end else begin
            case (r_state)
                BOOT: w_state_nxt = RUN;
                RUN: begin
                    if (bus.i_stall) begin
                        // A fetch completing under stall is parked so it is never re-fetched.
                        if (bus.i_imem_ack) begin
                            w_skid_instr_nxt = bus.i_imem_data;
                            w_skid_pc_nxt    = r_pc;
                            w_pc_nxt         = w_pc4;
                            w_state_nxt      = HOLD;
                        end
                    end else if (bus.i_imem_ack) begin
                        w_ifid_instr_nxt = bus.i_imem_data;
                        w_ifid_pc_nxt    = r_pc;
                        w_ifid_pc4_nxt   = w_pc4;
                        w_ifid_valid_nxt = 1'b1;
                        w_pc_nxt         = w_pc4;
                    end else begin
                        w_ifid_instr_nxt = NOP;
                        w_ifid_pc_nxt    = '0;
                        w_ifid_pc4_nxt   = '0;
                        w_ifid_valid_nxt = 1'b0;
                    end
                end
                HOLD: begin
                    if (!bus.i_stall) begin
                        w_ifid_instr_nxt = r_skid_instr;
                        w_ifid_pc_nxt    = r_skid_pc;
                        w_ifid_pc4_nxt   = w_skid_pc4;
                        w_ifid_valid_nxt = 1'b1;
                        w_state_nxt      = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, PC, IF/ID and skid registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_ifid_instr <= NOP;
            r_ifid_pc    <= '0;
            r_ifid_pc4   <= '0;
            r_ifid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_pc4   <= w_ifid_pc4_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky misaligned flag, cleared only by reset.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_misaligned_nxt;
        end
    end
    assign bus.o_misaligned = r_misaligned;
`else
    assign bus.o_misaligned = 1'b0;
`endif

    assign bus.o_imem_req   = (r_state == RUN);
    assign bus.o_imem_addr  = r_pc;
    assign bus.o_ifid_instr = r_ifid_instr;
    assign bus.o_ifid_pc    = r_ifid_pc;
    assign bus.o_ifid_pc4   = r_ifid_pc4;
    assign bus.o_ifid_valid = r_ifid_valid;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand-written corner sequences, then random traffic against a queue-based model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: stall and ack are driven directly by the bench.
module tb_fetch_unit;
    localparam int PW = 32;
    localparam int IW = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

    fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(32'h0)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic [1:0] ps, input logic fl, input logic [31:0] bt, input logic [31:0] jt,
                         input logic st, input logic ack, input logic [31:0] dat);
        bus.i_pcSrc         = ps;
        bus.i_flush         = fl;
        bus.i_branch_target = bt;
        bus.i_jalr_target   = jt;
        bus.i_stall         = st;
        bus.i_imem_ack      = ack;
        bus.i_imem_data     = dat;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  ps;  logic fl; logic [31:0] bt; logic [31:0] jt;
        logic        st;  logic ack; logic [31:0] dat;
        logic        req; logic [31:0] addr; logic v; logic [31:0] pc; logic [31:0] instr;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] ps, input logic fl, input logic [31:0] bt, input logic [31:0] jt,
                                input logic st, input logic ack, input logic [31:0] dat,
                                input logic req, input logic [31:0] addr, input logic v,
                                input logic [31:0] pc, input logic [31:0] instr);
        vec_t r;
        r = '{ps, fl, bt, jt, st, ack, dat, req, addr, v, pc, instr};
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4; logic valid; } ifid_t;
    logic [31:0] m_pc;
    ifid_t       m_ifid;
    ifid_t       m_parked[$];
    bit          m_boot, m_halt, m_mis;

    function automatic ifid_t bubble();
        ifid_t b;
        b = '{instr: NOP, pc: 32'h0, pc4: 32'h0, valid: 1'b0};
        return b;
    endfunction

    task automatic model_reset();
        m_pc   = 32'h0;
        m_ifid = bubble();
        m_parked.delete();
        m_boot = 1'b1;
        m_halt = 1'b0;
        m_mis  = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] ps, input logic fl, input logic [31:0] bt, input logic [31:0] jt,
                              input logic st, input logic ack, input logic [31:0] dat);
        bit          redir;
        logic [31:0] tgt;
        redir = (ps == 2'd1) || (ps == 2'd2);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            // frozen until reset
        end else if (fl || redir) begin
            m_ifid = bubble();
            m_parked.delete();
            if (redir) begin
                tgt = (ps == 2'd1) ? bt : (jt & 32'hFFFF_FFFE);
`ifdef FETCH_MISALIGN_TRAP_EN
                if (tgt % 4 != 0) begin
                    m_halt = 1'b1;
                    m_mis  = 1'b1;
                end else m_pc = tgt;
`else
                m_pc = tgt - (tgt % 4);
`endif
            end
        end else if (m_parked.size() > 0) begin
            if (!st) m_ifid = m_parked.pop_front();
        end else if (st) begin
            if (ack) begin
                m_parked.push_back('{instr: dat, pc: m_pc, pc4: m_pc + 32'd4, valid: 1'b1});
                m_pc = m_pc + 32'd4;
            end
        end else if (ack) begin
            m_ifid = '{instr: dat, pc: m_pc, pc4: m_pc + 32'd4, valid: 1'b1};
            m_pc   = m_pc + 32'd4;
        end else begin
            m_ifid = bubble();
        end
    endtask

    task automatic model_check(input int cyc);
        logic exp_req;
        exp_req = !m_boot && !m_halt && (m_parked.size() == 0);
        chk($sformatf("rnd%0d req", cyc), {31'b0, bus.o_imem_req}, {31'b0, exp_req});
        if (!m_halt) chk($sformatf("rnd%0d addr", cyc), bus.o_imem_addr, m_pc);
        chk($sformatf("rnd%0d instr", cyc), bus.o_ifid_instr, m_ifid.instr);
        chk($sformatf("rnd%0d pc", cyc), bus.o_ifid_pc, m_ifid.pc);
        chk($sformatf("rnd%0d pc4", cyc), bus.o_ifid_pc4, m_ifid.pc4);
        chk($sformatf("rnd%0d valid", cyc), {31'b0, bus.o_ifid_valid}, {31'b0, m_ifid.valid});
        chk($sformatf("rnd%0d mis", cyc), {31'b0, bus.o_misaligned}, {31'b0, m_mis});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req"}, {31'b0, bus.o_imem_req}, 32'h0);
        chk({tag, " addr"}, bus.o_imem_addr, 32'h0);
        chk({tag, " valid"}, {31'b0, bus.o_ifid_valid}, 32'h0);
        chk({tag, " instr"}, bus.o_ifid_instr, NOP);
        chk({tag, " pc"}, bus.o_ifid_pc, 32'h0);
        chk({tag, " pc4"}, bus.o_ifid_pc4, 32'h0);
        chk({tag, " mis"}, {31'b0, bus.o_misaligned}, 32'h0);
    endtask

    initial begin
        vec_t tbl[27];
        logic [31:0] B;
        logic [1:0]  ps;
        logic        fl, st, ack;
        logic [31:0] bt, jt, dat;
        int          r;

        B = 32'hBAD0_0000;
        //            ps    fl    bt            jt            st    ack   dat            req   addr          v     pc            instr
        tbl[0]  = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, B,             1'b1, 32'h0,        1'b0, 32'h0,        NOP);
        tbl[1]  = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hA000_0000, 1'b1, 32'h4,        1'b1, 32'h0,        32'hA000_0000);
        tbl[2]  = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hA000_0004, 1'b1, 32'h8,        1'b1, 32'h4,        32'hA000_0004);
        tbl[3]  = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hA000_0008, 1'b1, 32'hC,        1'b1, 32'h8,        32'hA000_0008);
        tbl[4]  = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hA000_000C, 1'b1, 32'h10,       1'b1, 32'hC,        32'hA000_000C);
        tbl[5]  = mk(2'd1, 1'b1, 32'h40,       32'h0,        1'b0, 1'b1, B,             1'b1, 32'h40,       1'b0, 32'h0,        NOP);
        tbl[6]  = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hB000_0040, 1'b1, 32'h44,       1'b1, 32'h40,       32'hB000_0040);
        tbl[7]  = mk(2'd2, 1'b0, 32'h0,        32'h101,      1'b0, 1'b1, B,             1'b1, 32'h100,      1'b0, 32'h0,        NOP);
        tbl[8]  = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, B,             1'b1, 32'h100,      1'b0, 32'h0,        NOP);
        tbl[9]  = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hC000_0100, 1'b1, 32'h104,      1'b1, 32'h100,      32'hC000_0100);
        tbl[10] = mk(2'd1, 1'b0, 32'h1C,       32'h0,        1'b0, 1'b0, B,             1'b1, 32'h1C,       1'b0, 32'h0,        NOP);
        tbl[11] = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hD000_001C, 1'b1, 32'h20,       1'b1, 32'h1C,       32'hD000_001C);
        tbl[12] = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'hD000_0020, 1'b0, 32'h24,       1'b1, 32'h1C,       32'hD000_001C);
        tbl[13] = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, B,             1'b0, 32'h24,       1'b1, 32'h1C,       32'hD000_001C);
        tbl[14] = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, B,             1'b0, 32'h24,       1'b1, 32'h1C,       32'hD000_001C);
        tbl[15] = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, B,             1'b1, 32'h24,       1'b1, 32'h20,       32'hD000_0020);
        tbl[16] = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hD000_0024, 1'b1, 32'h28,       1'b1, 32'h24,       32'hD000_0024);
        tbl[17] = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hD000_0028, 1'b1, 32'h2C,       1'b1, 32'h28,       32'hD000_0028);
        tbl[18] = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hD000_002C, 1'b1, 32'h30,       1'b1, 32'h2C,       32'hD000_002C);
        tbl[19] = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 32'hD000_0030, 1'b0, 32'h34,       1'b1, 32'h2C,       32'hD000_002C);
        tbl[20] = mk(2'd1, 1'b1, 32'h80,       32'h0,        1'b1, 1'b1, B,             1'b1, 32'h80,       1'b0, 32'h0,        NOP);
        tbl[21] = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hE000_0080, 1'b1, 32'h84,       1'b1, 32'h80,       32'hE000_0080);
        tbl[22] = mk(2'd0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1, B,             1'b1, 32'h84,       1'b0, 32'h0,        NOP);
        tbl[23] = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hE000_0084, 1'b1, 32'h88,       1'b1, 32'h84,       32'hE000_0084);
        tbl[24] = mk(2'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, B,             1'b1, 32'h88,       1'b1, 32'h84,       32'hE000_0084);
        tbl[25] = mk(2'd2, 1'b0, 32'h0,        32'h201,      1'b1, 1'b1, B,             1'b1, 32'h200,      1'b0, 32'h0,        NOP);
        tbl[26] = mk(2'd3, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hF000_0200, 1'b1, 32'h204,      1'b1, 32'h200,      32'hF000_0200);

        // Reset state
        drive(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot req", {31'b0, bus.o_imem_req}, 32'h0);

        // Directed vector table
        for (int k = 0; k < 27; k++) begin
            drive(tbl[k].ps, tbl[k].fl, tbl[k].bt, tbl[k].jt, tbl[k].st, tbl[k].ack, tbl[k].dat);
            step();
            chk($sformatf("vec%0d req", k), {31'b0, bus.o_imem_req}, {31'b0, tbl[k].req});
            chk($sformatf("vec%0d addr", k), bus.o_imem_addr, tbl[k].addr);
            chk($sformatf("vec%0d valid", k), {31'b0, bus.o_ifid_valid}, {31'b0, tbl[k].v});
            chk($sformatf("vec%0d pc", k), bus.o_ifid_pc, tbl[k].pc);
            chk($sformatf("vec%0d instr", k), bus.o_ifid_instr, tbl[k].instr);
            chk($sformatf("vec%0d pc4", k), bus.o_ifid_pc4, tbl[k].v ? tbl[k].pc + 32'd4 : 32'h0);
        end

        // PC wrap at the top of the address space
        drive(2'd1, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, B);
        step();
        chk("wrap addr", bus.o_imem_addr, 32'hFFFF_FFFC);
        drive(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7777_0000);
        step();
        chk("wrap next addr", bus.o_imem_addr, 32'h0);
        chk("wrap ifid pc", bus.o_ifid_pc, 32'hFFFF_FFFC);
        chk("wrap ifid pc4", bus.o_ifid_pc4, 32'h0);
        chk("wrap ifid instr", bus.o_ifid_instr, 32'h7777_0000);

        // Misaligned branch target 0x42
        drive(2'd1, 1'b1, 32'h42, 32'h0, 1'b0, 1'b1, B);
        step();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("trap mis", {31'b0, bus.o_misaligned}, 32'h1);
        chk("trap req", {31'b0, bus.o_imem_req}, 32'h0);
        chk("trap valid", {31'b0, bus.o_ifid_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
            step();
            chk($sformatf("halt%0d req", k), {31'b0, bus.o_imem_req}, 32'h0);
            chk($sformatf("halt%0d mis", k), {31'b0, bus.o_misaligned}, 32'h1);
            chk($sformatf("halt%0d instr", k), bus.o_ifid_instr, NOP);
        end
        rst_n = 1'b0;
        #1;
        chk("trap reset mis", {31'b0, bus.o_misaligned}, 32'h0);
        chk("trap reset req", {31'b0, bus.o_imem_req}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
`else
        chk("align addr", bus.o_imem_addr, 32'h40);
        chk("align mis", {31'b0, bus.o_misaligned}, 32'h0);
        chk("align req", {31'b0, bus.o_imem_req}, 32'h1);
`endif

        // Asynchronous reset mid-operation with an ack pending
        drive(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555_0000);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        step();
        chk_reset_outputs("async held");

        // Random traffic against the reference model
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            r  = $urandom_range(0, 99);
            ps = (r < 8) ? 2'd1 : (r < 12) ? 2'd2 : (r < 15) ? 2'd3 : 2'd0;
            fl = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 2) != 0);
            bt = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 39) == 0) ? 32'h2 : 32'h0);
            jt = ($urandom & 32'hFFFF_FFFD) | (($urandom_range(0, 39) == 0) ? 32'h2 : 32'h0);
            dat = $urandom;
            drive(ps, fl, bt, jt, st, ack, dat);
            step();
            model_step(ps, fl, bt, jt, st, ack, dat);
            model_check(c);
            if (c % 400 == 399) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                model_check(c);
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
